emac_mdio_master: RTL and testbench
===================================

# emac_mdio_master

Serial MDIO management master that implements the responder side of the EMAC host interface. It accepts single-cycle `hostreq` operations from the Wishbone MDIO register block and executes each as one IEEE 802.3 management frame on MDC/MDIO. It returns read data on `hostrddata` and signals completion by raising `hostmiimrdy`. It sits between that register block and the SFP/PHY management pins (via an IOBUF).

## Interface
Parameters:
- `CLK_DIV`, 20: MDC half-period in `hostclk` cycles (D). Must be ≥1. f_MDC = f_hostclk/(2·D).
- `PREAMBLE_LEN`, 32: number of preamble ones, 0..32.
- `CLAUSE45`, 0: ST field is 00 when 1, 01 when 0.

Ports:
- `hostclk` in 1: sole clock.
- `hostrst` in 1: synchronous, active-high reset.
- `hostreq` in 1: one-cycle operation request.
- `hostmiimsel` in 1: request is accepted only when 1. Config accesses (0) are ignored.
- `hostopcode` in 2: MDIO OP field. `hostopcode[1]`=1 selects a read-type frame.
- `hostaddr` in 10: [9:5] PHYAD/PRTAD, [4:0] REGAD/DEVAD.
- `hostwrdata` in 32: [15:0] write/address data. [31:16] are ignored.
- `hostrddata` out 32: {16'b0, last read data}.
- `hostmiimrdy` out 1: 1 = idle, ready to accept.
- `mdc` out 1: management clock.
- `mdio_o` out 1: MDIO output data.
- `mdio_t` out 1: tristate control, 1 = released (high-Z).
- `mdio_i` in 1: MDIO input data.

## Operation
- States: IDLE, FRAME, TAIL.
- IDLE:
  - Outputs: `mdc`=0, `mdio_t`=1, `mdio_o`=1.
  - Acceptance: `hostreq`=1 with `hostmiimsel`=1 at edge N latches opcode, address and wrdata[15:0], enters FRAME, and drives `hostmiimrdy`=0 from cycle N+1.
- FRAME: shifts F = PREAMBLE_LEN+32 bits, MSB first, in this order:
  - preamble (ones)
  - ST
  - OP = hostopcode
  - PHYAD
  - REGAD
  - TA
  - DATA[15:0]
- Write-type frame (`hostopcode[1]`=0):
  - TA = 10, DATA = latched wrdata.
  - `mdio_t`=0 for all F bits.
- Read-type frame (`hostopcode[1]`=1):
  - `mdio_t`=0 through REGAD.
  - `mdio_t`=1 from the first TA bit to the end of the frame.
  - `mdio_i` is sampled once per DATA bit into a 16-bit shift register.
- TAIL: one extra bit period with `mdc` toggling normally, `mdio_t`=1, `mdio_o`=1. Then return to IDLE.
- Completion:
  - For read-type frames, `hostrddata` is loaded with {16'b0, shift register} in the same cycle `hostmiimrdy` rises.
  - Write-type frames leave `hostrddata` unchanged.
  - `hostrddata` holds until the next read completes.
- Ignored without effect on outputs:
  - `hostreq` while not IDLE.
  - `hostreq` with `hostmiimsel`=0 (`hostmiimrdy` stays 1).
- Input changes after acceptance have no effect on the frame in progress.
- Counters:
  - Divider counts 0..D-1.
  - Bit counter counts 0..F (F ≤ 64, 7 bits).
  - Both wrap to 0 only on leaving IDLE.

## Timing
- Reset values (from the edge where `hostrst`=1 is sampled):
  - State IDLE, `mdc`=0, `mdio_o`=1, `mdio_t`=1, `hostmiimrdy`=1, `hostrddata`=0, shift register=0.
- Reset mid-frame aborts immediately with the same values. No TAIL is emitted.
- Bit period b (0..F, where b=F is TAIL) occupies cycles N+1+2Db through N+2D(b+1):
  - `mdio_o`/`mdio_t` update on the first cycle of the period (the MDC falling-edge point).
  - `mdc`=0 for the first D cycles, 1 for the next D.
- `mdio_i` is registered on the cycle `mdc` goes 0→1 in each DATA bit period.
- `hostmiimrdy` rises at cycle N+1+2D(F+1).
  - Total busy = 2D(F+1) cycles; defaults give 2600.
- A new `hostreq` may be accepted in the same cycle `hostmiimrdy` is 1.
- Back-to-back operations: the next frame's bit 0 starts the cycle after acceptance.

## Test plan
- Reset: assert `hostrst` 3 cycles mid-idle → `hostmiimrdy`=1, `mdc`=0, `mdio_t`=1, `mdio_o`=1, `hostrddata`=0x00000000.
- Clause-22 write, defaults: opcode 01, addr {00001,00000}, wrdata 0x0000A5C3.
  - Serial stream = 32 ones, 01, 01, 00001, 00000, 10, 1010010111000011.
  - `mdio_t`=0 for all 64 bits.
  - `hostmiimrdy` low exactly 2600 cycles.
  - `hostrddata` unchanged.
- Clause-22 read: opcode 10, addr {11111,00010}, PHY model drives 0x0141 after each MDC rise.
  - `mdio_t`=1 from TA bit 0 onward.
  - `hostrddata`=0x00000141 on the cycle `hostmiimrdy` rises.
- Ignored requests:
  - `hostreq` pulses at busy cycles 5 and 1000 → a single frame only.
  - `hostreq` with `hostmiimsel`=0 in IDLE → `hostmiimrdy` stays 1, `mdc` static.
- Reset mid-read at busy cycle 1500 → next cycle IDLE values, `hostrddata`=0.
  - A subsequent read of 0xBEEF completes normally.
- `CLAUSE45`=1, `PREAMBLE_LEN`=0, `CLK_DIV`=1: opcode 00 (address), addr {00011,00001}, data 0x1234.
  - Stream starts 00 00 00011 00001 10.
  - `mdc` toggles every cycle.
  - Busy exactly 66 cycles.

Source files
------------

// File: rtl/emac_mdio_master.sv
// MDIO management master: turns one accepted host request into a single
// IEEE 802.3 clause-22/45 management frame on MDC/MDIO, then returns read data.
module emac_mdio_master #(
    parameter int CLK_DIV      = 20,
    parameter int PREAMBLE_LEN = 32,
    parameter int CLAUSE45     = 0
) (
    input  logic        hostclk,
    input  logic        hostrst,
    input  logic        hostreq,
    input  logic        hostmiimsel,
    input  logic [1:0]  hostopcode,
    input  logic [9:0]  hostaddr,
    input  logic [31:0] hostwrdata,
    output logic [31:0] hostrddata,
    output logic        hostmiimrdy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);

    localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int                FRAME_BITS = PREAMBLE_LEN + 32;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]        FRAME_END  = 7'(FRAME_BITS);
    localparam logic [1:0]        ST_FIELD   = (CLAUSE45 != 0) ? 2'b00 : 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        TAIL
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   divCnt_q, divCnt_d;
    logic [6:0]         bitCnt_q, bitCnt_d;
    logic               mdc_q, mdc_d;
    logic               mdioO_q, mdioO_d;
    logic               mdioT_q, mdioT_d;
    logic               rdy_q, rdy_d;
    logic               isRead_q, isRead_d;
    logic [31:0]        word_q, word_d;
    logic [15:0]        rdShift_q, rdShift_d;
    logic [15:0]        rdData_q, rdData_d;

    logic               divLast;
    logic               inDataBit;
    logic [6:0]         nextBit;
    logic               unusedWrHi;

    // Returns {tristate, data} for a frame bit; the 32-bit word holds ST..DATA
    // and the preamble is implied. A read releases the line from TA onward.
    function automatic logic [1:0] bitDrive(input logic [6:0] bitIdx,
                                            input logic [31:0] word,
                                            input logic isRd);
        int         fieldIdx;
        logic [1:0] drive;
        fieldIdx = int'(bitIdx) - PREAMBLE_LEN;
        if (int'(bitIdx) >= FRAME_BITS) begin
            drive = 2'b11;
        end else if (fieldIdx < 0) begin
            drive = 2'b01;
        end else if (isRd && (fieldIdx >= 14)) begin
            drive = 2'b11;
        end else begin
            drive = {1'b0, word[5'(31 - fieldIdx)]};
        end
        return drive;
    endfunction

    assign divLast    = (divCnt_q == DIV_LAST);
    assign nextBit    = 7'(bitCnt_q + 7'd1);
    assign inDataBit  = (int'(bitCnt_q) >= PREAMBLE_LEN + 16) && (int'(bitCnt_q) < FRAME_BITS);
    assign unusedWrHi = ^hostwrdata[31:16];

    // Next-state logic: the divider paces MDC; a falling point ends a bit period.
    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q;
        bitCnt_d  = bitCnt_q;
        mdc_d     = mdc_q;
        mdioO_d   = mdioO_q;
        mdioT_d   = mdioT_q;
        rdy_d     = rdy_q;
        isRead_d  = isRead_q;
        word_d    = word_q;
        rdShift_d = rdShift_q;
        rdData_d  = rdData_q;

        case (state_q)
            IDLE: begin
                if (hostreq && hostmiimsel) begin
                    state_d  = FRAME;
                    divCnt_d = '0;
                    bitCnt_d = '0;
                    mdc_d    = 1'b0;
                    rdy_d    = 1'b0;
                    isRead_d = hostopcode[1];
                    word_d   = {ST_FIELD, hostopcode, hostaddr,
                                (hostopcode[1] ? 2'b11 : 2'b10), hostwrdata[15:0]};
                    {mdioT_d, mdioO_d} = bitDrive(7'd0, word_d, hostopcode[1]);
                end
            end

            FRAME, TAIL: begin
                if (divLast) begin
                    divCnt_d = '0;
                    mdc_d    = ~mdc_q;
                    if (!mdc_q) begin
                        if (isRead_q && inDataBit) begin
                            rdShift_d = {rdShift_q[14:0], mdio_i};
                        end
                    end else if (state_q == TAIL) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                        mdioO_d = 1'b1;
                        mdioT_d = 1'b1;
                        if (isRead_q) begin
                            rdData_d = rdShift_q;
                        end
                    end else begin
                        bitCnt_d = nextBit;
                        {mdioT_d, mdioO_d} = bitDrive(nextBit, word_q, isRead_q);
                        if (nextBit == FRAME_END) begin
                            state_d = TAIL;
                        end
                    end
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in progress without a tail.
    always_ff @(posedge hostclk) begin
        if (hostrst) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            bitCnt_q  <= '0;
            mdc_q     <= 1'b0;
            mdioO_q   <= 1'b1;
            mdioT_q   <= 1'b1;
            rdy_q     <= 1'b1;
            isRead_q  <= 1'b0;
            word_q    <= '0;
            rdShift_q <= '0;
            rdData_q  <= '0;
        end else begin
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            bitCnt_q  <= bitCnt_d;
            mdc_q     <= mdc_d;
            mdioO_q   <= mdioO_d;
            mdioT_q   <= mdioT_d;
            rdy_q     <= rdy_d;
            isRead_q  <= isRead_d;
            word_q    <= word_d;
            rdShift_q <= rdShift_d;
            rdData_q  <= rdData_d;
        end
    end

    assign hostrddata  = {16'h0000, rdData_q};
    assign hostmiimrdy = rdy_q;
    assign mdc         = mdc_q;
    assign mdio_o      = mdioO_q;
    assign mdio_t      = mdioT_q;

endmodule

// File: tb/tb_emac_mdio_master.sv
// Bench for emac_mdio_master: a default-parameter instance and a fast
// clause-45 instance, both checked cycle by cycle against a frame model.
module tb_emac_mdio_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqA, reqB, sel;
    logic [1:0]  opcode;
    logic [9:0]  addr;
    logic [31:0] wrdata;
    logic        mdioIn = 1'b1;

    logic [31:0] rdA, rdB;
    logic        rdyA, rdyB, mdcA, mdcB, oA, oB, tA, tB;

    logic        useB = 1'b0;
    logic        curMdc, curO, curT, curRdy;
    logic [31:0] curRd;

    int          vecCount = 0;
    int          errCount = 0;
    logic [31:0] expRd [2];

    logic [15:0] phyData = 16'h0000;
    bit          phyActive = 1'b0;
    int          phyRise = 0;
    int          phyPre;
    logic        prevMdc = 1'b0;

    logic        obsMdc [0:2700];
    logic        obsO   [0:2700];
    logic        obsT   [0:2700];

    always #5 clk = ~clk;

    emac_mdio_master dutA (
        .hostclk(clk), .hostrst(rst), .hostreq(reqA), .hostmiimsel(sel),
        .hostopcode(opcode), .hostaddr(addr), .hostwrdata(wrdata),
        .hostrddata(rdA), .hostmiimrdy(rdyA), .mdc(mdcA),
        .mdio_o(oA), .mdio_t(tA), .mdio_i(mdioIn)
    );

    emac_mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(0), .CLAUSE45(1)) dutB (
        .hostclk(clk), .hostrst(rst), .hostreq(reqB), .hostmiimsel(sel),
        .hostopcode(opcode), .hostaddr(addr), .hostwrdata(wrdata),
        .hostrddata(rdB), .hostmiimrdy(rdyB), .mdc(mdcB),
        .mdio_o(oB), .mdio_t(tB), .mdio_i(mdioIn)
    );

    assign curMdc = useB ? mdcB : mdcA;
    assign curO   = useB ? oB   : oA;
    assign curT   = useB ? tB   : tA;
    assign curRdy = useB ? rdyB : rdyA;
    assign curRd  = useB ? rdB  : rdA;
    assign phyPre = useB ? 0 : 32;

    // PHY model: after the MDC rise of the second TA bit it presents DATA[15],
    // then one bit after each following rise; other bits are random noise.
    always @(negedge clk) begin
        prevMdc <= curMdc;
        if (curRdy) begin
            phyRise <= 0;
        end else if (curMdc && !prevMdc) begin
            phyRise <= phyRise + 1;
            if (phyActive && phyRise == phyPre + 15)
                mdioIn <= phyData[15];
            else if (phyActive && phyRise >= phyPre + 16 && phyRise <= phyPre + 30)
                mdioIn <= phyData[4'(30 + phyPre - phyRise)];
            else
                mdioIn <= 1'($urandom);
        end
    end

    task automatic checkIdle(input string name, input logic [31:0] expData);
        vecCount++;
        if ({curRdy, curMdc, curO, curT, curRd} !== {1'b1, 1'b0, 1'b1, 1'b1, expData})
            $display("[TB] FAIL %s: rdy/mdc/o/t/rddata observed %b/%b/%b/%b/%h, expected 1/0/1/1/%h",
                     name, curRdy, curMdc, curO, curT, curRd, expData);
        if ({curRdy, curMdc, curO, curT, curRd} !== {1'b1, 1'b0, 1'b1, 1'b1, expData})
            errCount++;
    endtask

    // One frame on the selected instance, checked bit period by bit period.
    task automatic runFrame(input bit onB, input logic [1:0] op, input logic [9:0] ad,
                            input logic [15:0] wd, input logic [15:0] phyVal,
                            input int pulse1, input int pulse2, input int abortAt);
        int         d, p, f, busy, c, lastRec, bad;
        bit         finished, aborted, isRd;
        logic [1:0] st;
        logic       exO[$];
        logic       exT[$];
        logic       seenO, seenT, seenMdc;

        d    = onB ? 1 : 20;
        p    = onB ? 0 : 32;
        st   = onB ? 2'b00 : 2'b01;
        f    = p + 32;
        busy = 2 * d * (f + 1);
        isRd = op[1];

        for (int i = 0; i < p; i++) begin exO.push_back(1'b1); exT.push_back(1'b0); end
        exO.push_back(st[1]); exO.push_back(st[0]);
        exO.push_back(op[1]); exO.push_back(op[0]);
        for (int i = 9; i >= 0; i--) exO.push_back(ad[i]);
        for (int i = 0; i < 14; i++) exT.push_back(1'b0);
        if (isRd) begin
            for (int i = 0; i < 18; i++) begin exO.push_back(1'b1); exT.push_back(1'b1); end
        end else begin
            exO.push_back(1'b1); exO.push_back(1'b0);
            for (int i = 15; i >= 0; i--) exO.push_back(wd[i]);
            for (int i = 0; i < 18; i++) exT.push_back(1'b0);
        end
        exO.push_back(1'b1); exT.push_back(1'b1);

        useB      = onB;
        phyActive = isRd;
        phyData   = phyVal;
        sel       = 1'b1;
        opcode    = op;
        addr      = ad;
        wrdata    = {16'($urandom), wd};
        if (onB) reqB = 1'b1; else reqA = 1'b1;
        @(negedge clk);
        reqA = 1'b0; reqB = 1'b0;
        opcode = 2'($urandom); addr = 10'($urandom); wrdata = $urandom;

        c = 1; lastRec = 0; finished = 0; aborted = 0;
        while (!finished) begin
            if (curRdy) begin
                finished = 1;
            end else begin
                obsMdc[c] = curMdc; obsO[c] = curO; obsT[c] = curT;
                lastRec = c;
                if (c == pulse1 || c == pulse2) begin
                    if (onB) reqB = 1'b1; else reqA = 1'b1;
                end
                if (c == abortAt) rst = 1'b1;
                @(negedge clk);
                reqA = 1'b0; reqB = 1'b0;
                if (c == abortAt) begin
                    aborted = 1; finished = 1;
                end
                c++;
                if (!finished && c > busy + 8) begin
                    vecCount++; errCount++;
                    $display("[TB] FAIL frame_timeout: still busy after %0d cycles, expected %0d", c - 1, busy);
                    finished = 1;
                end
            end
        end

        for (int b = 0; b <= f; b++) begin
            if (1 + 2 * d * b <= lastRec) begin
                bad = 0; seenO = exO[b]; seenT = exT[b];
                for (int k = 1 + 2 * d * b; k <= 2 * d * (b + 1) && k <= lastRec; k++) begin
                    if (obsT[k] !== exT[b] || (exT[b] == 1'b0 && obsO[k] !== exO[b])) begin
                        if (bad == 0) begin seenO = obsO[k]; seenT = obsT[k]; end
                        bad++;
                    end
                end
                vecCount++;
                if (bad != 0) begin
                    errCount++;
                    $display("[TB] FAIL frame_bit%0d: observed o/t=%b/%b, expected o/t=%b/%b",
                             b, seenO, seenT, exO[b], exT[b]);
                end
            end
        end

        bad = 0; seenMdc = 1'b0;
        for (int k = 1; k <= lastRec; k++) begin
            if (obsMdc[k] !== (((k - 1) % (2 * d)) >= d)) begin
                if (bad == 0) seenMdc = obsMdc[k];
                bad++;
            end
        end
        vecCount++;
        if (bad != 0) begin
            errCount++;
            $display("[TB] FAIL mdc_pattern: %0d wrong cycles, first observed %b", bad, seenMdc);
        end

        if (aborted) begin
            rst = 1'b0;
            expRd[0] = 32'h0; expRd[1] = 32'h0;
            checkIdle("reset_abort", 32'h0);
        end else if (lastRec == c - 1) begin
            vecCount++;
            if (c - 1 != busy) begin
                errCount++;
                $display("[TB] FAIL busy_length: observed %0d cycles, expected %0d", c - 1, busy);
            end
            if (isRd) expRd[int'(onB)] = {16'h0000, phyVal};
            checkIdle(isRd ? "read_data" : "write_keeps_rddata", expRd[int'(onB)]);
        end
    endtask

    task automatic idleHold(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (curRdy !== 1'b1 || curMdc !== 1'b0 || curT !== 1'b1) bad++;
        end
        vecCount++;
        if (bad != 0) begin
            errCount++;
            $display("[TB] FAIL %s: %0d idle cycles showed activity, expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expRd[0] = 32'h0; expRd[1] = 32'h0;
        useB = 1'b0; checkIdle("reset_A", 32'h0);
        useB = 1'b1; checkIdle("reset_B", 32'h0);
    endtask

    task automatic test_c22_write();
        runFrame(1'b0, 2'b01, {5'b00001, 5'b00000}, 16'hA5C3, 16'h0000, -1, -1, -1);
    endtask

    task automatic test_c22_read();
        runFrame(1'b0, 2'b10, {5'b11111, 5'b00010}, 16'($urandom), 16'h0141, -1, -1, -1);
    endtask

    // Requests while busy and config-space requests must not start a frame.
    task automatic test_ignored();
        runFrame(1'b0, 2'b10, 10'($urandom), 16'($urandom), 16'($urandom), 5, 1000, -1);
        idleHold("no_second_frame", 50);
        useB = 1'b0; sel = 1'b0; reqA = 1'b1;
        @(negedge clk);
        reqA = 1'b0;
        idleHold("sel0_ignored_A", 120);
        checkIdle("sel0_rddata_A", expRd[0]);
        useB = 1'b1; reqB = 1'b1;
        @(negedge clk);
        reqB = 1'b0; sel = 1'b1;
        idleHold("sel0_ignored_B", 20);
    endtask

    task automatic test_reset_mid_read();
        runFrame(1'b0, 2'b10, 10'($urandom), 16'($urandom), 16'h1357, -1, -1, 1500);
        runFrame(1'b0, 2'b11, 10'($urandom), 16'($urandom), 16'hBEEF, -1, -1, -1);
    endtask

    task automatic test_clause45();
        runFrame(1'b1, 2'b00, {5'b00011, 5'b00001}, 16'h1234, 16'h0000, -1, -1, -1);
        for (int i = 0; i < 24; i++)
            runFrame(1'b1, 2'($urandom), 10'($urandom), 16'($urandom), 16'($urandom), -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        runFrame(1'b0, 2'b01, 10'($urandom), 16'($urandom), 16'($urandom), -1, -1, -1);
        runFrame(1'b0, 2'b10, 10'($urandom), 16'($urandom), 16'($urandom), -1, -1, -1);
        runFrame(1'b0, 2'b00, 10'($urandom), 16'($urandom), 16'($urandom), -1, -1, -1);
    endtask

    initial begin
        rst = 1'b1; reqA = 1'b0; reqB = 1'b0; sel = 1'b1;
        opcode = 2'b00; addr = '0; wrdata = '0;
        expRd[0] = 32'h0; expRd[1] = 32'h0;
        @(negedge clk);
        test_reset();
        test_c22_write();
        test_c22_read();
        test_ignored();
        test_reset_mid_read();
        repeat (5) @(negedge clk);
        test_reset();
        test_clause45();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
